// File: rtl/decompress_match_stage.sv
// ----------------------------------------------------------------------------
// decompress_match_stage
//
// Decompression half of the two-word matching stage. It takes one beat holding
// two pre-parsed codewords (pattern type, dictionary slot, literal) and rebuilds
// the original 64-bit word. It also keeps a FIFO dictionary whose insertion
// policy is identical to the compressor's, so that both sides always hold the
// same dictionary contents.
//
// Ports
//   i_clk        clock
//   i_reset      asynchronous, active-low reset
//   i_valid      input beat valid
//   o_ready      stage can accept a beat (~o_valid | i_ready)
//   i_type0/1    pattern code per word: 0 ZZZZ, 1 ZZZX, 2 MMMM, 3 MMMX,
//                4 MMXX, 5 XXXX, 6-7 illegal
//   i_loc0/1     dictionary slot referenced by the M* patterns
//   i_lit0/1     literal bytes, LSB-aligned
//   o_valid      o_word holds a reconstructed beat
//   i_ready      downstream accepts o_word
//   o_word       {word1, word0}, with word0 in [WORD-1:0]
//   o_dict_full  every dictionary slot has been written at least once
//   o_err        sticky flag for an illegal pattern code
// ----------------------------------------------------------------------------
module decompress_match_stage #(
   parameter int WIDTH      = 64,
   parameter int WORD       = 32,
   parameter int DICT_ENTRY = 16,
   localparam int LOC_W     = $clog2(DICT_ENTRY)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_type0,
   input  logic [LOC_W-1:0] i_loc0,
   input  logic [WORD-1:0]  i_lit0,
   input  logic [2:0]       i_type1,
   input  logic [LOC_W-1:0] i_loc1,
   input  logic [WORD-1:0]  i_lit1,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_word,
   output logic             o_dict_full,
   output logic             o_err
);

   localparam logic [2:0] T_ZZZZ = 3'd0;
   localparam logic [2:0] T_ZZZX = 3'd1;
   localparam logic [2:0] T_MMMM = 3'd2;
   localparam logic [2:0] T_MMMX = 3'd3;
   localparam logic [2:0] T_MMXX = 3'd4;
   localparam logic [2:0] T_XXXX = 3'd5;

   localparam logic [LOC_W-1:0] LAST_SLOT = LOC_W'(DICT_ENTRY - 1);

   // Rebuild one word from its pattern, its dictionary entry and its literal.
   function automatic logic [WORD-1:0] rebuild_word(
      input logic [2:0]      t,
      input logic [WORD-1:0] d,
      input logic [WORD-1:0] l
   );
      logic [WORD-1:0] w;
      w = '0;
      case (t)
         T_ZZZZ: w = '0;
         T_ZZZX: w = {{(WORD-8){1'b0}}, l[7:0]};
         T_MMMM: w = d;
         T_MMMX: w = {d[WORD-1:8], l[7:0]};
         T_MMXX: w = {d[WORD-1:16], l[15:0]};
         T_XXXX: w = l;
         default: w = '0;
      endcase
      return w;
   endfunction

   // Only patterns that carry fresh literal bytes enter the dictionary.
   function automatic logic pushes(input logic [2:0] t);
      return (t == T_MMMX) || (t == T_MMXX) || (t == T_XXXX);
   endfunction

   function automatic logic illegal(input logic [2:0] t);
      return t > T_XXXX;
   endfunction

   logic [WORD-1:0]  dict [DICT_ENTRY];
   logic [LOC_W-1:0] wp;

   logic             accept;
   logic [WORD-1:0]  w0_p0;
   logic [WORD-1:0]  w1_p0;
   logic [WORD-1:0]  d1_p0;
   logic             push0_p0;
   logic             push1_p0;
   logic [LOC_W-1:0] wp_after0_p0;
   logic [LOC_W-1:0] wp_next_p0;
   logic             hit_last_p0;
   logic             err_p0;

   logic             vld_p1;
   logic [WIDTH-1:0] word_p1;
   logic             full_p1;
   logic             err_p1;

   assign o_ready = ~vld_p1 | i_ready;
   assign accept  = i_valid & o_ready;

   // ---- stage p0: combinational decode of both words ----
   always_comb begin
      push0_p0     = pushes(i_type0);
      push1_p0     = pushes(i_type1);
      w0_p0        = rebuild_word(i_type0, dict[i_loc0], i_lit0);
      wp_after0_p0 = push0_p0 ? wp + 1'b1 : wp;
      // word1 must see word0's push; the array write has not happened yet,
      // so the fresh value is bypassed from word0's reconstruction.
      d1_p0        = (push0_p0 && (i_loc1 == wp)) ? w0_p0 : dict[i_loc1];
      w1_p0        = rebuild_word(i_type1, d1_p0, i_lit1);
      wp_next_p0   = push1_p0 ? wp_after0_p0 + 1'b1 : wp_after0_p0;
      hit_last_p0  = (push0_p0 && (wp == LAST_SLOT)) ||
                     (push1_p0 && (wp_after0_p0 == LAST_SLOT));
      err_p0       = illegal(i_type0) | illegal(i_type1);
   end

   // ---- stage p1: dictionary, pointer and output register ----
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wp <= '0;
         for (int i = 0; i < DICT_ENTRY; i++) begin
            dict[i] <= '0;
         end
      end else if (accept) begin
         wp <= wp_next_p0;
         for (int i = 0; i < DICT_ENTRY; i++) begin
            // Two pushes always land in distinct slots (wp and wp+1).
            if (push0_p0 && (wp == LOC_W'(i))) begin
               dict[i] <= w0_p0;
            end
            if (push1_p0 && (wp_after0_p0 == LOC_W'(i))) begin
               dict[i] <= w1_p0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         vld_p1  <= 1'b0;
         word_p1 <= '0;
         full_p1 <= 1'b0;
         err_p1  <= 1'b0;
      end else begin
         if (accept) begin
            vld_p1  <= 1'b1;
            word_p1 <= {w1_p0, w0_p0};
            if (hit_last_p0) begin
               full_p1 <= 1'b1;
            end
            if (err_p0) begin
               err_p1 <= 1'b1;
            end
         end else if (i_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign o_valid     = vld_p1;
   assign o_word      = word_p1;
   assign o_dict_full = full_p1;
   assign o_err       = err_p1;

endmodule

// File: tb/tb_decompress_match_stage.sv
// ----------------------------------------------------------------------------
// tb_decompress_match_stage
//
// Directed bench for decompress_match_stage: fixed beats with hand-computed
// reconstructed words, covering literal/match patterns, in-beat forwarding,
// dictionary wrap and the full flag, backpressure, illegal codes and an
// asynchronous reset while a beat is held.
// ----------------------------------------------------------------------------
module tb_decompress_match_stage;

   localparam logic [2:0] ZZZZ = 3'd0;
   localparam logic [2:0] ZZZX = 3'd1;
   localparam logic [2:0] MMMM = 3'd2;
   localparam logic [2:0] MMMX = 3'd3;
   localparam logic [2:0] MMXX = 3'd4;
   localparam logic [2:0] XXXX = 3'd5;
   localparam logic [2:0] BAD7 = 3'd7;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_type0;
   logic [3:0]  i_loc0;
   logic [31:0] i_lit0;
   logic [2:0]  i_type1;
   logic [3:0]  i_loc1;
   logic [31:0] i_lit1;
   logic        o_valid;
   logic        i_ready;
   logic [63:0] o_word;
   logic        o_dict_full;
   logic        o_err;

   int n_checks;
   int n_fails;

   decompress_match_stage dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_type0     (i_type0),
      .i_loc0      (i_loc0),
      .i_lit0      (i_lit0),
      .i_type1     (i_type1),
      .i_loc1      (i_loc1),
      .i_lit1      (i_lit1),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_word      (o_word),
      .o_dict_full (o_dict_full),
      .o_err       (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   // Present one beat from a falling edge, wait (bounded) for o_ready, let the
   // rising edge accept it, and return 1 time unit after that edge.
   task automatic beat(input logic [2:0] t0, input logic [3:0] l0, input logic [31:0] v0,
                       input logic [2:0] t1, input logic [3:0] l1, input logic [31:0] v1);
      int n;
      @(negedge clk);
      i_type0 = t0; i_loc0 = l0; i_lit0 = v0;
      i_type1 = t1; i_loc1 = l1; i_lit1 = v1;
      i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) check("beat_ready_timeout", 64'(o_ready), 64'd1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   logic [63:0] held;

   initial begin
      n_checks = 0;
      n_fails  = 0;
      i_valid = 1'b0; i_ready = 1'b1;
      i_type0 = ZZZZ; i_loc0 = '0; i_lit0 = '0;
      i_type1 = ZZZZ; i_loc1 = '0; i_lit1 = '0;

      do_reset();
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_word", o_word, 64'd0);
      check("rst_err", 64'(o_err), 64'd0);
      check("rst_full", 64'(o_dict_full), 64'd0);
      check("rst_ready", 64'(o_ready), 64'd1);

      // Two literals into slots 0 and 1
      beat(XXXX, 4'd0, 32'hDEADBEEF, XXXX, 4'd0, 32'h12345678);
      check("t1_valid", 64'(o_valid), 64'd1);
      check("t1_word", o_word, 64'h12345678_DEADBEEF);

      // Partial matches against slots 0 and 1; pushes into slots 2 and 3
      beat(MMMX, 4'd0, 32'h00000011, MMXX, 4'd1, 32'h0000AAAA);
      check("t2_word", o_word, 64'h1234AAAA_DEADBE11);
      beat(MMMM, 4'd2, 32'h0, MMMM, 4'd3, 32'h0);
      check("t2_slots23", o_word, 64'h1234AAAA_DEADBE11);

      // word1 reads the slot word0 just pushed (slot 4)
      beat(XXXX, 4'd0, 32'hCAFEF00D, MMMM, 4'd4, 32'h0);
      check("t3_forward", o_word, 64'hCAFEF00D_CAFEF00D);

      // Zero patterns push nothing; wp still 5, so slot 5 is forwarded next
      beat(ZZZZ, 4'd0, 32'hFFFFFFFF, ZZZX, 4'd0, 32'hFFFFFF7F);
      check("t4_zero", o_word, 64'h0000007F_00000000);
      beat(XXXX, 4'd0, 32'h00000055, MMMM, 4'd5, 32'h0);
      check("t4_wp_kept", o_word, 64'h00000055_00000055);

      // Wrap: fill slots 0..15 with 1..16, then 17 overwrites slot 0
      do_reset();
      for (int k = 0; k < 8; k++) begin
         beat(XXXX, 4'd0, 32'(2*k+1), XXXX, 4'd0, 32'(2*k+2));
         if (k == 6) check("t5_not_full", 64'(o_dict_full), 64'd0);
      end
      check("t5_full", 64'(o_dict_full), 64'd1);
      check("t5_last", o_word, {32'd16, 32'd15});
      beat(XXXX, 4'd0, 32'd17, MMMM, 4'd0, 32'h0);
      check("t5_wrap_fwd", o_word, {32'd17, 32'd17});
      beat(MMMM, 4'd0, 32'h0, MMMM, 4'd15, 32'h0);
      check("t5_wrap_lookup", o_word, {32'd16, 32'd17});
      check("t5_full_sticky", 64'(o_dict_full), 64'd1);

      // Backpressure: hold a beat, offer another that must not be taken
      beat(MMMM, 4'd1, 32'h0, MMMM, 4'd2, 32'h0);
      i_ready = 1'b0;
      check("t6_held_word", o_word, {32'd3, 32'd2});
      held = o_word;
      @(negedge clk);
      i_type0 = XXXX; i_lit0 = 32'h99; i_type1 = XXXX; i_lit1 = 32'h98;
      i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t6_not_ready", 64'(o_ready), 64'd0);
         @(negedge clk);
         check("t6_stable", o_word, held);
         check("t6_still_valid", 64'(o_valid), 64'd1);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t6_drained", 64'(o_valid), 64'd0);
      beat(MMMM, 4'd1, 32'h0, ZZZZ, 4'd0, 32'h0);
      check("t6_no_dict_change", o_word, {32'd0, 32'd2});

      // Illegal code on word0; word1 still decoded and pushed into slot 1
      beat(BAD7, 4'd0, 32'hFFFFFFFF, XXXX, 4'd0, 32'hABCD0123);
      check("t6_err_word", o_word, 64'hABCD0123_00000000);
      check("t6_err_flag", 64'(o_err), 64'd1);
      beat(ZZZX, 4'd0, 32'h00000005, MMMM, 4'd1, 32'h0);
      check("t6_after_err", o_word, 64'hABCD0123_00000005);
      check("t6_err_sticky", 64'(o_err), 64'd1);

      // Async reset while a beat is held
      i_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(o_valid), 64'd0);
      check("t6_rst_word", o_word, 64'd0);
      check("t6_rst_err", 64'(o_err), 64'd0);
      check("t6_rst_full", 64'(o_dict_full), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      i_ready = 1'b1;
      #1;
      check("t6_rst_ready", 64'(o_ready), 64'd1);
      beat(MMMM, 4'd0, 32'h0, MMMM, 4'd1, 32'h0);
      check("t6_dict_cleared", o_word, 64'd0);
      check("t6_post_valid", 64'(o_valid), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
